// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, retiring UNROLL
// bits per cycle. Divides by zero and the signed-overflow divide finish one
// cycle after acceptance. The result is held under a valid/ready handshake,
// and flush abandons any operation in flight.
module muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            busy
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    // Two's complement negate when requested.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // High half of a conditionally negated 2*XLEN product. Negating the full
    // product carries into the high half only when the low half is zero.
    function automatic logic [XLEN-1:0] fix_high(input logic [2*XLEN-1:0] p, input logic neg);
        logic [XLEN-1:0] carry;
        carry = {{(XLEN-1){1'b0}}, (p[XLEN-1:0] == '0)};
        return neg ? (~p[2*XLEN-1:XLEN] + carry) : p[2*XLEN-1:XLEN];
    endfunction

    // Control and iteration state.
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic [XLEN-1:0]   res_q, res_d;

    // Operand decode in IDLE.
    logic            a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    // One CALC cycle worth of iteration.
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   div_rem, div_quo;
    logic [XLEN:0]     div_sh, div_diff;
    logic [XLEN-1:0]   res_calc;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign res       = res_q;

    // Classify the incoming request: operand magnitudes, result sign, fast paths.
    always_comb begin
        a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
        b_sgn = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg = a_sgn & src1[XLEN-1];
        b_neg = b_sgn & src2[XLEN-1];
        mag_a = cond_neg(src1, a_neg);
        mag_b = cond_neg(src2, b_neg);
        // Remainder follows the dividend; product and quotient follow the sign xor.
        neg_in   = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = funct3[2] && (src2 == '0);
        div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                   (src1 == MIN_INT) && (src2 == '1);
        fast     = div_zero | div_ovf;
        if (div_zero) begin
            fast_res = funct3[1] ? src1 : '1;
        end else begin
            fast_res = funct3[1] ? '0 : MIN_INT;
        end
    end

    // Shift-add multiply: the low half holds the remaining multiplier bits,
    // the high half accumulates, and the pair shifts right once per bit.
    always_comb begin
        mul_acc = prod_q;
        mul_sum = '0;
        for (int i = 0; i < UNROLL; i++) begin
            mul_sum = {1'b0, mul_acc[2*XLEN-1:XLEN]} + (mul_acc[0] ? {1'b0, mcand_q} : '0);
            mul_acc = {mul_sum, mul_acc[XLEN-1:1]};
        end
    end

    // Restoring divide: bring down one dividend bit, trial-subtract, keep the
    // difference when it is non-negative. The shifted partial remainder needs
    // a guard bit, and the trial difference fits in XLEN+1 bits as a signed value.
    always_comb begin
        div_rem  = rem_q;
        div_quo  = quo_q;
        div_sh   = '0;
        div_diff = '0;
        for (int i = 0; i < UNROLL; i++) begin
            div_sh   = {div_rem, div_quo[XLEN-1]};
            div_quo  = {div_quo[XLEN-2:0], 1'b0};
            div_diff = div_sh - {1'b0, dvsr_q};
            if (!div_diff[XLEN]) begin
                div_rem    = div_diff[XLEN-1:0];
                div_quo[0] = 1'b1;
            end else begin
                div_rem = div_sh[XLEN-1:0];
            end
        end
    end

    // Final result selection with sign fixup, used on the last CALC cycle.
    always_comb begin
        case (op_q)
            3'b000:  res_calc = mul_acc[XLEN-1:0];
            3'b001:  res_calc = fix_high(mul_acc, neg_q);
            3'b010:  res_calc = fix_high(mul_acc, neg_q);
            3'b011:  res_calc = mul_acc[2*XLEN-1:XLEN];
            3'b100:  res_calc = cond_neg(div_quo, neg_q);
            3'b101:  res_calc = div_quo;
            3'b110:  res_calc = cond_neg(div_rem, neg_q);
            default: res_calc = div_rem;
        endcase
    end

    // Next-state logic; flush wins over acceptance, completion and out_ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        res_d   = res_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d    = funct3;
                        neg_d   = neg_in;
                        prod_d  = {{XLEN{1'b0}}, mag_b};
                        mcand_d = mag_a;
                        rem_d   = '0;
                        quo_d   = mag_a;
                        dvsr_d  = mag_b;
                        if (fast) begin
                            res_d   = fast_res;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = CNT_INIT;
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (op_q[2]) begin
                        rem_d = div_rem;
                        quo_d = div_quo;
                    end else begin
                        prod_d = mul_acc;
                    end
                    if (cnt_q == CNT_ONE) begin
                        res_d   = res_calc;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, handshake,
// flush and reset behaviour, then randomized operations against an
// arithmetic reference model.
module tb_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
);

    localparam int STEPS = XLEN / UNROLL;
    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] res;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .UNROLL(UNROLL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        longint          ua, ub, sa, sb, r;
        longint unsigned pu;
        logic            ovf;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = a[XLEN-1] ? ua - (longint'(1) << XLEN) : ua;
        sb  = b[XLEN-1] ? ub - (longint'(1) << XLEN) : ub;
        ovf = (a == MINV) && (b == ONES);
        case (f3)
            3'd0: r = ua * ub;
            3'd1: r = (sa * sb) >>> XLEN;
            3'd2: r = (sa * ub) >>> XLEN;
            3'd3: begin
                pu = $unsigned(ua) * $unsigned(ub);
                pu = pu >> XLEN;
                r  = longint'(pu);
            end
            3'd4: r = (b == '0) ? -1 : (ovf ? sa : sa / sb);
            3'd5: r = (b == '0) ? -1 : ua / ub;
            3'd6: r = (b == '0) ? sa : (ovf ? 0 : sa % sb);
            default: r = (b == '0) ? ua : ua % ub;
        endcase
        return r[XLEN-1:0];
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        return f3[2] && ((b == '0) || (!f3[0] && a == MINV && b == ONES));
    endfunction

    // Issue one request, check latency, result and busy/ready, hold the result
    // for 'hold' cycles under backpressure, then retire it.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input int hold);
        logic [XLEN-1:0] exp;
        int              exp_lat, lat;
        bit              rdy_low, stable;
        exp     = ref_model(f3, a, b);
        exp_lat = is_fast(f3, a, b) ? 1 : STEPS + 1;
        lat = 0;
        while (!in_ready && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, ":in_ready"}, in_ready, 1);
        funct3   = f3;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        src1     = XLEN'($urandom);
        src2     = XLEN'($urandom);
        lat      = 1;
        rdy_low  = 1'b1;
        while (!out_valid && lat < STEPS + 8) begin
            if (in_ready || !busy) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, ":latency"}, lat, exp_lat);
        check_eq({tag, ":busy_during"}, rdy_low, 1);
        check_eq({tag, ":res"}, res, exp);
        check_eq({tag, ":done_flags"}, {in_ready, busy}, 2'b01);
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!out_valid || res !== exp) stable = 1'b0;
        end
        check_eq({tag, ":held"}, stable, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, ":retired"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        logic [XLEN-1:0] prev, a, b;
        logic [2:0]      f3;
        bit              seen;
        int              mode, flush_at;

        flush_at  = (STEPS > 6) ? 4 : 1;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct3    = '0;
        src1      = '0;
        src2      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset:flags", {out_valid, in_ready, busy}, 3'b010);
        check_eq("reset:res", res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7x6",   3'd0, XLEN'(7), XLEN'(6), 0);
        run_op("mulh_m1",   3'd1, ONES, ONES, 0);
        run_op("mulhu_max", 3'd3, ONES, ONES, 0);
        run_op("mulhsu",    3'd2, ONES, XLEN'(2), 0);
        run_op("div_m7_2",  3'd4, ONES - XLEN'(6), XLEN'(2), 0);
        run_op("rem_m7_2",  3'd6, ONES - XLEN'(6), XLEN'(2), 0);
        run_op("divu_16",   3'd5, ONES, XLEN'(16), 0);
        run_op("remu_16",   3'd7, ONES, XLEN'(16), 0);
        run_op("divu_z",    3'd5, XLEN'(5), '0, 0);
        run_op("remu_z",    3'd7, XLEN'(5), '0, 0);
        run_op("div_ovf",   3'd4, MINV, ONES, 0);
        run_op("rem_ovf",   3'd6, MINV, ONES, 0);
        run_op("div_z",     3'd4, ONES, '0, 0);
        run_op("rem_z",     3'd6, MINV, '0, 0);
        run_op("mul_big",   3'd0, XLEN'(32'h12345678), XLEN'(32'h9ABCDEF0), 0);
        run_op("div_100_7", 3'd4, XLEN'(100), XLEN'(7), 0);
        run_op("backpress", 3'd1, XLEN'($urandom), XLEN'($urandom), 10);
        run_op("back2back", 3'd5, XLEN'($urandom), XLEN'(3), 0);

        // Flush in the middle of CALC: back to IDLE, result untouched, no out_valid.
        prev     = res;
        funct3   = 3'd0;
        src1     = XLEN'(123);
        src2     = XLEN'(45);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (flush_at) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_calc:flags", {out_valid, in_ready, busy}, 3'b010);
        check_eq("flush_calc:res", res, prev);
        seen = 1'b0;
        repeat (STEPS + 4) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check_eq("flush_calc:quiet", seen, 0);

        // Request together with flush in IDLE is dropped.
        funct3   = 3'd4;
        src1     = XLEN'(9);
        src2     = XLEN'(0);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("flush_idle:flags", {out_valid, in_ready, busy}, 3'b010);
        check_eq("flush_idle:res", res, prev);

        // Flush while a result waits in DONE discards it but keeps res.
        funct3   = 3'd5;
        src1     = XLEN'(5);
        src2     = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("flush_done:valid", out_valid, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_done:flags", {out_valid, in_ready, busy}, 3'b010);
        check_eq("flush_done:res", res, ref_model(3'd5, XLEN'(5), '0));

        // Asynchronous reset mid-CALC clears outputs without a clock edge.
        funct3   = 3'd3;
        src1     = ONES;
        src2     = ONES;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst:flags", {out_valid, in_ready, busy}, 3'b010);
        check_eq("async_rst:res", res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 3'd2, ONES, XLEN'(2), 0);

        // Randomized operations with biased operand corners.
        for (int n = 0; n < 150; n++) begin
            f3   = 3'($urandom);
            a    = XLEN'($urandom);
            b    = XLEN'($urandom);
            mode = $urandom_range(0, 7);
            case (mode)
                0: b = '0;
                1: begin a = MINV; b = ONES; end
                2: begin a = XLEN'($urandom_range(0, 300)); b = XLEN'($urandom_range(1, 20)); end
                3: b = XLEN'($urandom_range(1, 4)) ^ (($urandom_range(0, 1) == 1) ? ONES : '0);
                default: ;
            endcase
            run_op($sformatf("rnd%0d_f%0d", n, f3), f3, a, b, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. Handles the M-extension opcodes (0110011 with funct7 0000001) that the single-cycle combinational ALU does not cover.
- Sits beside the ALU in the execute stage. Decode raises in_valid for M-ops and stalls issue until out_valid/out_ready completes.
- Parametrised in datapath width and radix (bits retired per cycle). Has a valid/ready handshake and a flush input.

Parameters:
XLEN, 32, operand/result width; even, >= 8.
UNROLL, 1, bits processed per CALC cycle; must divide XLEN (1, 2, 4, 8 legal).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  abort current operation; the result is discarded.
in_valid  input  1  request present.
in_ready  output  1  unit can accept; equals (state==IDLE).
funct3  input  3  op select: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
src1  input  XLEN  rs1 operand (multiplicand/dividend).
src2  input  XLEN  rs2 operand (multiplier/divisor).
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  consumer accepts result.
res  output  XLEN  result; stable while out_valid=1.
busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, out_valid=0, res=0, busy=0, in_ready=1, all iteration registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On in_valid&&in_ready, capture funct3 and operands.
  - Signed ops (mulh: both operands; mulhsu: src1 only; div/rem: both) are converted to magnitude. Result sign is recorded.
  - Fast paths go straight to DONE next cycle (latency 1):
    - div/divu with src2==0: res = all-ones.
    - rem/remu with src2==0: res = src1.
    - div with src1=MIN_INT and src2=-1: res = MIN_INT.
    - rem with src1=MIN_INT and src2=-1: res = 0.
  - Otherwise go to CALC with counter = XLEN/UNROLL.
- CALC:
  - Multiply: shift-add over a 2*XLEN product register, UNROLL multiplier bits per cycle.
  - Divide: restoring division, UNROLL quotient bits per cycle, XLEN-wide remainder with one guard bit.
  - Counter decrements each cycle. When counter reaches 1, the next state is DONE.
  - On entry to DONE the result is formed:
    - mul: low XLEN of the product.
    - mulh/mulhsu/mulhu: high XLEN of the product.
    - div/divu: quotient.
    - rem/remu: remainder.
  - Sign fixup (two's complement negate) applies for signed ops:
    - Quotient negated when the operand signs differ.
    - Remainder takes the dividend's sign.
    - Product for mulh/mulhsu: the full 2*XLEN product is negated before the high half is selected.
- Latency (accept edge to out_valid=1):
  - Normal ops: XLEN/UNROLL + 1 cycles.
  - Fast paths: 1 cycle.
- DONE:
  - out_valid=1 and res held.
  - out_ready=1 → IDLE on the next edge, out_valid drops. A new request is not accepted in the same cycle (in_ready=0 in DONE).
  - out_ready=0 → remain in DONE indefinitely.
- flush=1 in any state → IDLE on the next edge, out_valid=0, res unchanged. flush takes priority over accept, completion and out_ready in the same cycle.
- A request in IDLE together with flush is dropped.
- Inputs are sampled only at acceptance; src1/src2 changing during CALC has no effect.
- funct3 is always legal (3-bit full decode). funct7 is filtered upstream.

Test Plan:
- XLEN=32, UNROLL=1: mul 7×6 → res=42; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- mulh 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
- mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- mulhsu 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- div 0xFFFFFFF9(-7)/2 → 0xFFFFFFFD.
- rem 0xFFFFFFF9(-7)/2 → 0xFFFFFFFF.
- divu 0xFFFFFFFF/0x10 → 0x0FFFFFFF.
- remu 0xFFFFFFFF/0x10 → 0xF.
- Fast paths, latency 1 each:
  - divu 5/0 → 0xFFFFFFFF.
  - remu 5/0 → 5.
  - div 0x80000000/0xFFFFFFFF → 0x80000000.
  - rem 0x80000000/0xFFFFFFFF → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → res stable and out_valid held. Raise out_ready → IDLE next cycle; accept the back-to-back request the following cycle.
- Flush: assert flush at CALC cycle 5 → IDLE next edge, no out_valid. Assert rst_n=0 mid-CALC → all outputs at reset values immediately, without waiting for a clock edge.
- Recompile with UNROLL=4: mul 0x12345678×0x9ABCDEF0 → low 0x242D2080; latency 9 cycles.
- Recompile with XLEN=16, UNROLL=2: div 0x8000/0xFFFF → 0x8000 (1 cycle).
- Recompile with XLEN=16, UNROLL=2: div 100/7 → 14 (9 cycles).
